// File: rtl/datapath_hazard_if.sv
// Bus between the hazard-protected MIPS datapath, its controller and imem/dmem.
// stallD means "not ready": the instruction in ID is held and flushE bubbles the EX control bits.
interface datapath_hazard_if;
  logic        regwriteE, regwriteM, regwriteW;
  logic        memtoregE, memtoregM, memtoregW;
  logic        regdstE, alusrcE;
  logic [2:0]  alucontrolE;
  logic        branchD, jumpD;
  logic [31:0] instrF, readdataM;
  logic [31:0] pcF, instrD, aluoutM, writedataM;
  logic        overflowE, stallF, stallD, flushE;

  modport master (
    output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memtoregW,
           regdstE, alusrcE, alucontrolE, branchD, jumpD, instrF, readdataM,
    input  pcF, instrD, aluoutM, writedataM, overflowE, stallF, stallD, flushE
  );

  modport slave (
    input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, memtoregW,
           regdstE, alusrcE, alucontrolE, branchD, jumpD, instrF, readdataM,
    output pcF, instrD, aluoutM, writedataM, overflowE, stallF, stallD, flushE
  );
endinterface

// File: rtl/datapath_hazard.sv
// 5-stage MIPS integer datapath with forwarding, load-use/branch interlocks and
// ID-stage branch/jump resolution that squashes the IF/ID register.
module datapath_hazard #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          FWD_EN   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  datapath_hazard_if.slave bus
);
  logic [31:0] pc_q, pc_d;
  logic [31:0] instrd_q, instrd_d, pcplus4d_q, pcplus4d_d;
  logic [31:0] rd1e_q, rd2e_q, imme_q;
  logic [4:0]  rse_q, rte_q, rde_q;
  logic [31:0] aluoutm_q, writedatam_q, aluoutw_q, readdataw_q;
  logic [4:0]  writeregm_q, writeregw_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rsd, rtd, rdd, writerege;
  logic [31:0] signimmd, rd1d, rd2d, cmpad, cmpbd, resultw;
  logic [31:0] pcplus4f, pcbranchd, pcjumpd;
  logic        pcsrcd, redirect, lwstall, branchstall, rawstall, stall;
  logic [31:0] srcae, writedatae, srcbe, sume, diffe, aluoute;
  logic        overflowe;

  function automatic logic src_hit(input logic [4:0] w, input logic [4:0] a, input logic [4:0] b);
    return (w != 5'd0) && ((w == a) || (w == b));
  endfunction

  assign rsd      = instrd_q[25:21];
  assign rtd      = instrd_q[20:16];
  assign rdd      = instrd_q[15:11];
  assign signimmd = {{16{instrd_q[15]}}, instrd_q[15:0]};
  assign resultw  = bus.memtoregW ? readdataw_q : aluoutw_q;

  // Same-cycle WB write is visible to the ID read.
  assign rd1d = (rsd == 5'd0) ? 32'd0 :
                (bus.regwriteW && writeregw_q == rsd) ? resultw : rf_q[rsd];
  assign rd2d = (rtd == 5'd0) ? 32'd0 :
                (bus.regwriteW && writeregw_q == rtd) ? resultw : rf_q[rtd];

  assign cmpad = (FWD_EN && rsd != 5'd0 && bus.regwriteM && writeregm_q == rsd) ? aluoutm_q : rd1d;
  assign cmpbd = (FWD_EN && rtd != 5'd0 && bus.regwriteM && writeregm_q == rtd) ? aluoutm_q : rd2d;

  assign pcsrcd     = bus.branchD && (cmpad == cmpbd);
  assign redirect   = bus.jumpD || pcsrcd;
  assign pcplus4f   = pc_q + 32'd4;
  assign pcbranchd  = pcplus4d_q + (signimmd << 2);
  assign pcjumpd    = {pcplus4d_q[31:28], instrd_q[25:0], 2'b00};
  assign pc_d       = bus.jumpD ? pcjumpd : (pcsrcd ? pcbranchd : pcplus4f);
  assign instrd_d   = redirect ? 32'd0 : bus.instrF;
  assign pcplus4d_d = redirect ? 32'd0 : pcplus4f;

  assign writerege   = bus.regdstE ? rde_q : rte_q;
  assign lwstall     = bus.memtoregE && src_hit(rte_q, rsd, rtd);
  assign branchstall = bus.branchD && ((bus.regwriteE && src_hit(writerege, rsd, rtd)) ||
                                       (bus.memtoregM && src_hit(writeregm_q, rsd, rtd)));
  assign rawstall    = (bus.regwriteE && src_hit(writerege, rsd, rtd)) ||
                       (bus.regwriteM && src_hit(writeregm_q, rsd, rtd)) ||
                       (bus.regwriteW && src_hit(writeregw_q, rsd, rtd));
  assign stall       = FWD_EN ? (lwstall || branchstall) : rawstall;

  // EX operand forwarding: MEM result beats WB result.
  always_comb begin
    srcae = rd1e_q;
    if (FWD_EN && rse_q != 5'd0) begin
      if (bus.regwriteM && writeregm_q == rse_q)      srcae = aluoutm_q;
      else if (bus.regwriteW && writeregw_q == rse_q) srcae = resultw;
    end
  end

  always_comb begin
    writedatae = rd2e_q;
    if (FWD_EN && rte_q != 5'd0) begin
      if (bus.regwriteM && writeregm_q == rte_q)      writedatae = aluoutm_q;
      else if (bus.regwriteW && writeregw_q == rte_q) writedatae = resultw;
    end
  end

  assign srcbe = bus.alusrcE ? imme_q : writedatae;
  assign sume  = srcae + srcbe;
  assign diffe = srcae - srcbe;

  always_comb begin
    aluoute   = 32'd0;
    overflowe = 1'b0;
    case (bus.alucontrolE)
      3'b010: begin
        aluoute   = sume;
        overflowe = (srcae[31] == srcbe[31]) && (sume[31] != srcae[31]);
      end
      3'b110: begin
        aluoute   = diffe;
        overflowe = (srcae[31] != srcbe[31]) && (diffe[31] != srcae[31]);
      end
      3'b000:  aluoute = srcae & srcbe;
      3'b001:  aluoute = srcae | srcbe;
      3'b111:  aluoute = {31'd0, ($signed(srcae) < $signed(srcbe))};
      default: aluoute = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && bus.regwriteW && writeregw_q != 5'd0) rf_q[writeregw_q] <= resultw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      instrd_q     <= 32'd0;
      pcplus4d_q   <= 32'd0;
      rd1e_q       <= 32'd0;
      rd2e_q       <= 32'd0;
      imme_q       <= 32'd0;
      rse_q        <= 5'd0;
      rte_q        <= 5'd0;
      rde_q        <= 5'd0;
      aluoutm_q    <= 32'd0;
      writedatam_q <= 32'd0;
      writeregm_q  <= 5'd0;
      aluoutw_q    <= 32'd0;
      readdataw_q  <= 32'd0;
      writeregw_q  <= 5'd0;
    end else begin
      if (!stall) begin
        pc_q       <= pc_d;
        instrd_q   <= instrd_d;
        pcplus4d_q <= pcplus4d_d;
      end
      if (stall) begin
        rd1e_q <= 32'd0;
        rd2e_q <= 32'd0;
        imme_q <= 32'd0;
        rse_q  <= 5'd0;
        rte_q  <= 5'd0;
        rde_q  <= 5'd0;
      end else begin
        rd1e_q <= rd1d;
        rd2e_q <= rd2d;
        imme_q <= signimmd;
        rse_q  <= rsd;
        rte_q  <= rtd;
        rde_q  <= rdd;
      end
      aluoutm_q    <= aluoute;
      writedatam_q <= writedatae;
      writeregm_q  <= writerege;
      aluoutw_q    <= aluoutm_q;
      readdataw_q  <= bus.readdataM;
      writeregw_q  <= writeregm_q;
    end
  end

  assign bus.pcF        = pc_q;
  assign bus.instrD     = instrd_q;
  assign bus.aluoutM    = aluoutm_q;
  assign bus.writedataM = writedatam_q;
  assign bus.overflowE  = overflowe;
  assign bus.stallF     = stall;
  assign bus.stallD     = stall;
  assign bus.flushE     = stall;
endmodule

// File: tb/tb_datapath_hazard.sv
// Directed bench: one forwarding and one interlock-only datapath run the same program
// behind a small controller/imem/dmem model; results are observed through stores.
module tb_datapath_hazard;
  localparam logic [31:0] SUB_I   = 32'h0022_2022; // sub $4,$1,$2
  localparam logic [31:0] ADD0_I  = 32'h0000_2820; // add $5,$0,$0
  localparam logic [31:0] LWUSE_I = 32'h0021_1020; // add $2,$1,$1
  localparam logic [31:0] BEQ_I   = 32'h10C4_0001; // beq $6,$4,+1

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem [128];
  int          tests = 0;
  int          fails = 0;

  logic [31:0] pc_o [2];
  logic [31:0] instrd_o [2];
  logic        stallf_o [2];
  logic        stalld_o [2];
  logic        flush_o [2];
  logic [31:0] mem_o [2][10];
  int          sub_st [2];
  int          add0_st [2];
  int          lwuse_st [2];
  int          br_st [2];
  int          tot_st [2];
  int          ovf_cnt [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // {regwrite, memtoreg, memwrite, regdst, alusrc, alucontrol[2:0]}
  function automatic logic [7:0] decode(input logic [31:0] ins);
    logic [7:0] c;
    c = 8'd0;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: c = 8'b1001_0010;
        6'h22: c = 8'b1001_0110;
        6'h24: c = 8'b1001_0000;
        6'h25: c = 8'b1001_0001;
        6'h2a: c = 8'b1001_0111;
        default: c = 8'd0;
      endcase
      6'h08: c = 8'b1000_1010;
      6'h23: c = 8'b1100_1010;
      6'h2b: c = 8'b0010_1010;
      default: c = 8'd0;
    endcase
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    datapath_hazard_if bus ();
    datapath_hazard #(.RESET_PC(32'h0000_0000), .FWD_EN(g == 0)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );

    logic [7:0]  ctl_e;
    logic [2:0]  ctl_m;
    logic [1:0]  ctl_w;
    logic [31:0] dmem [16];
    int          c_sub, c_add0, c_lwuse, c_br, c_tot, c_ovf;

    assign bus.branchD     = (bus.instrD[31:26] == 6'h04);
    assign bus.jumpD       = (bus.instrD[31:26] == 6'h02);
    assign bus.regwriteE   = ctl_e[7];
    assign bus.memtoregE   = ctl_e[6];
    assign bus.regdstE     = ctl_e[4];
    assign bus.alusrcE     = ctl_e[3];
    assign bus.alucontrolE = ctl_e[2:0];
    assign bus.regwriteM   = ctl_m[2];
    assign bus.memtoregM   = ctl_m[1];
    assign bus.regwriteW   = ctl_w[1];
    assign bus.memtoregW   = ctl_w[0];
    assign bus.instrF      = imem[bus.pcF[8:2]];
    assign bus.readdataM   = dmem[bus.aluoutM[5:2]];

    always_ff @(posedge clk) begin
      if (!rst) begin
        ctl_e <= 8'd0;
        ctl_m <= 3'd0;
        ctl_w <= 2'd0;
        for (int k = 0; k < 16; k++) dmem[k] <= 32'd0;
        dmem[0] <= 32'd9;
        dmem[2] <= 32'hdead_beef;
        dmem[7] <= 32'h7fff_ffff;
      end else begin
        ctl_e <= bus.flushE ? 8'd0 : decode(bus.instrD);
        ctl_m <= ctl_e[7:5];
        ctl_w <= ctl_m[2:1];
        if (ctl_m[0]) dmem[bus.aluoutM[5:2]] <= bus.writedataM;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        c_sub <= 0; c_add0 <= 0; c_lwuse <= 0; c_br <= 0; c_tot <= 0; c_ovf <= 0;
      end else begin
        if (bus.stallD) begin
          c_tot <= c_tot + 1;
          if (bus.instrD == SUB_I)   c_sub   <= c_sub + 1;
          if (bus.instrD == ADD0_I)  c_add0  <= c_add0 + 1;
          if (bus.instrD == LWUSE_I) c_lwuse <= c_lwuse + 1;
          if (bus.instrD == BEQ_I)   c_br    <= c_br + 1;
        end
        if (bus.overflowE) c_ovf <= c_ovf + 1;
      end
    end

    assign pc_o[g]     = bus.pcF;
    assign instrd_o[g] = bus.instrD;
    assign stallf_o[g] = bus.stallF;
    assign stalld_o[g] = bus.stallD;
    assign flush_o[g]  = bus.flushE;
    assign sub_st[g]   = c_sub;
    assign add0_st[g]  = c_add0;
    assign lwuse_st[g] = c_lwuse;
    assign br_st[g]    = c_br;
    assign tot_st[g]   = c_tot;
    assign ovf_cnt[g]  = c_ovf;
    for (genvar k = 0; k < 10; k++) begin : gen_mem
      assign mem_o[g][k] = dmem[k];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 128; k++) imem[k] = 32'd0;
    imem[0]  = itype(6'h08, 0, 2, 16'd5);
    imem[1]  = itype(6'h08, 0, 3, 16'd7);
    imem[2]  = rtype(2, 3, 1, 6'h20);
    imem[3]  = SUB_I;
    imem[4]  = itype(6'h2b, 0, 4, 16'd4);
    imem[5]  = itype(6'h08, 0, 0, 16'd3);
    imem[6]  = ADD0_I;
    imem[7]  = itype(6'h2b, 0, 5, 16'd8);
    imem[8]  = itype(6'h23, 0, 1, 16'd0);
    imem[9]  = LWUSE_I;
    imem[10] = itype(6'h2b, 0, 2, 16'd12);
    imem[11] = itype(6'h08, 0, 7, 16'd2);
    imem[12] = rtype(4, 0, 6, 6'h20);
    imem[13] = BEQ_I;
    imem[14] = itype(6'h08, 0, 7, 16'd1);
    imem[15] = itype(6'h2b, 0, 7, 16'd16);
    imem[16] = itype(6'h04, 1, 2, 16'd5);
    imem[17] = itype(6'h08, 0, 8, 16'd3);
    imem[18] = itype(6'h2b, 0, 8, 16'd20);
    imem[19] = itype(6'h08, 0, 9, 16'd4);
    imem[20] = {6'h02, 26'h40};
    imem[21] = itype(6'h08, 0, 9, 16'd1);
    imem[64] = itype(6'h2b, 0, 9, 16'd24);
    imem[65] = itype(6'h23, 0, 10, 16'd28);
    imem[66] = rtype(10, 10, 11, 6'h20);
    imem[67] = rtype(11, 0, 12, 6'h2a);
    imem[68] = itype(6'h2b, 0, 11, 16'd32);
    imem[69] = itype(6'h2b, 0, 12, 16'd36);
    imem[70] = {6'h02, 26'h46};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rst_pc_fwd", pc_o[0], 32'h0);
    check("rst_instrd_fwd", instrd_o[0], 32'h0);
    check("rst_pc_nofwd", pc_o[1], 32'h0);
    step();
    check("pc_c1", pc_o[0], 32'h4);
    check("instrd_c1", instrd_o[0], imem[0]);
    step();
    check("pc_c2", pc_o[0], 32'h8);
    step(); step();
    check("sub_no_stall", {31'd0, stallf_o[0]}, 32'd0);
    repeat (6) step();
    check("lwuse_stallf", {31'd0, stallf_o[0]}, 32'd1);
    check("lwuse_stalld", {31'd0, stalld_o[0]}, 32'd1);
    check("lwuse_flushe", {31'd0, flush_o[0]}, 32'd1);
    check("lwuse_pc", pc_o[0], 32'h28);
    step();
    check("lwuse_release", {31'd0, stallf_o[0]}, 32'd0);
    check("lwuse_pc_hold", pc_o[0], 32'h28);
    check("lwuse_instrd_hold", instrd_o[0], LWUSE_I);
    repeat (4) step();
    check("brstall_on", {31'd0, stallf_o[0]}, 32'd1);
    check("brstall_instrd", instrd_o[0], BEQ_I);
    step();
    check("brstall_off", {31'd0, stallf_o[0]}, 32'd0);
    step();
    check("beq_target", pc_o[0], 32'h3c);
    check("beq_squash", instrd_o[0], 32'h0);
    step(); step();
    check("bne_instrd", instrd_o[0], imem[16]);
    step();
    check("bnt_pc", pc_o[0], 32'h48);
    check("bnt_no_squash", instrd_o[0], imem[17]);
    repeat (4) step();
    check("j_target", pc_o[0], 32'h100);
    check("j_squash", instrd_o[0], 32'h0);

    repeat (300) step();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("mem_sub%0d", g),   mem_o[g][1], 32'd7);
      check($sformatf("mem_r0_%0d", g),   mem_o[g][2], 32'd0);
      check($sformatf("mem_lwuse%0d", g), mem_o[g][3], 32'd18);
      check($sformatf("mem_beq%0d", g),   mem_o[g][4], 32'd2);
      check($sformatf("mem_bnt%0d", g),   mem_o[g][5], 32'd3);
      check($sformatf("mem_j%0d", g),     mem_o[g][6], 32'd4);
      check($sformatf("mem_ovf%0d", g),   mem_o[g][8], 32'hffff_fffe);
      check($sformatf("mem_slt%0d", g),   mem_o[g][9], 32'd1);
      check($sformatf("ovf_cnt%0d", g),   ovf_cnt[g], 32'd1);
      check($sformatf("add0_stall%0d", g), add0_st[g], 32'd0);
    end
    check("sub_stall_fwd", sub_st[0], 32'd0);
    check("sub_stall_nofwd", sub_st[1], 32'd3);
    check("lwuse_stall_fwd", lwuse_st[0], 32'd1);
    check("lwuse_stall_nofwd", lwuse_st[1], 32'd3);
    check("br_stall_fwd", br_st[0], 32'd1);
    check("br_stall_nofwd", br_st[1], 32'd3);
    check("tot_stall_fwd", tot_st[0], 32'd3);

    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (10) step();
    check("restart_stall", {31'd0, stallf_o[0]}, 32'd1);
    rst = 1'b0;
    step();
    check("rst_over_stall_pc", pc_o[0], 32'h0);
    check("rst_over_stall_instrd", instrd_o[0], 32'h0);
    check("rst_over_stall_flag", {31'd0, stallf_o[0]}, 32'd0);
    rst = 1'b1;
    step();
    check("rst_restart_pc", pc_o[0], 32'h4);
    check("rst_restart_instrd", instrd_o[0], imem[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
